// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_ctrl_pkg : states, opcode/funct tables and select encodings     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_UPDATE  = 3'd4,
    S_DUMMY   = 3'd5,
    S_HALT    = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic opcode_known(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LW, OP_SW: opcode_known = 1'b1;
      default:                       opcode_known = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_alu_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_alu_decoder : opcode/funct -> ALU operation and imm extension   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mips_alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  ext_zero,
  output logic                  funct_valid
);

  always_comb begin
    alu_ctrl    = ALU_CTRL_W'(ALU_ADD);
    ext_zero    = 1'b0;
    funct_valid = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        funct_valid = 1'b1;
        case (funct)
          FN_ADD:  alu_ctrl = ALU_CTRL_W'(ALU_ADD);
          FN_SUB:  alu_ctrl = ALU_CTRL_W'(ALU_SUB);
          FN_AND:  alu_ctrl = ALU_CTRL_W'(ALU_AND);
          FN_OR:   alu_ctrl = ALU_CTRL_W'(ALU_OR);
          FN_NOR:  alu_ctrl = ALU_CTRL_W'(ALU_NOR);
          FN_SLT:  alu_ctrl = ALU_CTRL_W'(ALU_SLT);
          default: funct_valid = 1'b0;  // unknown funct degrades to a NOP add
        endcase
      end
      OP_SLTI: alu_ctrl = ALU_CTRL_W'(ALU_SLT);
      OP_ANDI: begin
        alu_ctrl = ALU_CTRL_W'(ALU_AND);
        ext_zero = 1'b1;
      end
      OP_ORI: begin
        alu_ctrl = ALU_CTRL_W'(ALU_OR);
        ext_zero = 1'b1;
      end
      OP_BEQ, OP_BNE: alu_ctrl = ALU_CTRL_W'(ALU_SUB);
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_multicycle_ctrl : 5-cycle main control FSM of the MIPS core.    |
// | Option MIPS_CTRL_ILLEGAL_TRAP_EN: unknown opcode halts, illegal_op.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W    = 3,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero,
  output logic [STATE_W-1:0]    count_state,
  output logic                  i_or_d,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic                  ext_zero,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [1:0]            pc_src,
  output logic                  pc_en,
  output logic                  instr_done
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                  illegal_op
`endif
);

  state_t                r_state;
  logic [ALU_CTRL_W-1:0] w_dec_alu_ctrl;
  logic                  w_dec_ext_zero;
  logic                  w_funct_valid;
  logic                  w_is_r;
  logic                  w_is_ialu;
  logic                  w_is_mem;

  mips_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .opcode      (opcode),
    .funct       (funct),
    .alu_ctrl    (w_dec_alu_ctrl),
    .ext_zero    (w_dec_ext_zero),
    .funct_valid (w_funct_valid)
  );

  assign w_is_r    = (opcode == OP_RTYPE);
  assign w_is_ialu = (opcode == OP_ADDI) || (opcode == OP_SLTI) ||
                     (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign w_is_mem  = (opcode == OP_LW) || (opcode == OP_SW);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    r_state <= enable ? S_FETCH : S_IDLE;
        S_FETCH:   r_state <= S_DECODE;
        S_DECODE: begin
          r_state <= S_EXECUTE;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
          if (!opcode_known(opcode)) r_state <= S_HALT;
`endif
        end
        S_EXECUTE: r_state <= S_UPDATE;
        S_UPDATE:  r_state <= S_DUMMY;
        S_DUMMY:   r_state <= enable ? S_FETCH : S_IDLE;
        S_HALT:    r_state <= S_HALT;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign count_state = STATE_W'(r_state);

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = (r_state == S_HALT);
`endif

  // Moore on state, qualified by the IR fields that are stable from DECODE on
  always_comb begin
    i_or_d     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    ext_zero   = 1'b0;
    alu_ctrl   = ALU_CTRL_W'(ALU_ADD);
    pc_src     = PCSRC_ALU;
    pc_en      = 1'b0;
    instr_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_en     = 1'b1;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_EXECUTE: begin
        if (w_is_r) begin
          alu_src_a = 1'b1;
          alu_ctrl  = w_dec_alu_ctrl;
        end else if (w_is_ialu || w_is_mem) begin
          // operand A is the base/source register for every immediate op
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_ctrl  = w_dec_alu_ctrl;
          ext_zero  = w_dec_ext_zero;
        end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
          alu_src_a = 1'b1;
          alu_ctrl  = ALU_CTRL_W'(ALU_SUB);
          pc_src    = PCSRC_ALUOUT;
          pc_en     = (opcode == OP_BEQ) ? zero : ~zero;
        end
      end
      S_UPDATE: begin
        if (w_is_r && w_funct_valid) begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end else if (w_is_ialu) begin
          reg_write = 1'b1;
        end else if (opcode == OP_LW) begin
          i_or_d = 1'b1;
        end else if (opcode == OP_SW) begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
        end else if (opcode == OP_J) begin
          pc_src = PCSRC_JUMP;
          pc_en  = 1'b1;
        end
      end
      S_DUMMY: begin
        instr_done = 1'b1;
        if (opcode == OP_LW) begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mips_multicycle_ctrl : directed vectors with a scoreboard queue   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] srcb;
    logic       ext_zero;
    logic [3:0] alu;
    logic [1:0] pc_src;
    logic       pc_en, instr_done, illegal;
  } vec_t;

  typedef struct {
    vec_t  exp;
    vec_t  mask;
    string name;
  } item_t;

  logic       clk = 1'b0;
  logic       reset, enable, zero;
  logic [5:0] opcode, funct;
  logic [2:0] count_state;
  logic       i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       ext_zero, pc_en, instr_done;
  logic [3:0] alu_ctrl;
  logic       illegal_w;
  vec_t       act;

  item_t      sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [2:0] es;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.STATE_W(3), .ALU_CTRL_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .opcode(opcode), .funct(funct),
    .zero(zero), .count_state(count_state), .i_or_d(i_or_d), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .alu_ctrl(alu_ctrl), .pc_src(pc_src), .pc_en(pc_en),
    .instr_done(instr_done)
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    , .illegal_op(illegal_w)
`endif
  );

`ifndef MIPS_CTRL_ILLEGAL_TRAP_EN
  assign illegal_w = 1'b0;
`endif

  assign act = {count_state, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, ext_zero, alu_ctrl, pc_src,
                pc_en, instr_done, illegal_w};

  function automatic logic known(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
  endfunction

  // Reference behaviour, written per instruction class
  function automatic vec_t model(input logic [2:0] st, input logic [5:0] op,
                                 input logic [5:0] fn, input logic z, output vec_t mask);
    vec_t v;
    logic ialu, fn_ok;
    v = '0;
    mask = '1;
    v.st = st;
    v.alu = 4'd2;
    ialu = op inside {6'h08, 6'h0A, 6'h0C, 6'h0D};
    fn_ok = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    if (st == 3'd1) begin
      v.ir_write = 1; v.srcb = 2'b01; v.pc_en = 1;
    end else if (st == 3'd2) begin
      v.srcb = 2'b11;
    end else if (st == 3'd3) begin
      if (op == 6'h00) begin
        v.alu_src_a = 1;
        case (fn)
          6'h22: v.alu = 4'd6;  6'h24: v.alu = 4'd0;  6'h25: v.alu = 4'd1;
          6'h27: v.alu = 4'd12; 6'h2A: v.alu = 4'd7;  default: v.alu = 4'd2;
        endcase
      end else if (ialu || op == 6'h23 || op == 6'h2B) begin
        v.srcb = 2'b10;
        mask.alu_src_a = 0;
        v.ext_zero = (op == 6'h0C || op == 6'h0D);
        v.alu = (op == 6'h0A) ? 4'd7 : (op == 6'h0C) ? 4'd0 : (op == 6'h0D) ? 4'd1 : 4'd2;
      end else if (op == 6'h04 || op == 6'h05) begin
        v.alu_src_a = 1; v.alu = 4'd6; v.pc_src = 2'b01;
        v.pc_en = (op == 6'h04) ? z : !z;
      end
    end else if (st == 3'd4) begin
      if (op == 6'h00 && fn_ok) begin v.reg_write = 1; v.reg_dst = 1; end
      if (ialu) v.reg_write = 1;
      if (op == 6'h23) v.i_or_d = 1;
      if (op == 6'h2B) begin v.i_or_d = 1; v.mem_write = 1; end
      if (op == 6'h02) begin v.pc_src = 2'b10; v.pc_en = 1; end
    end else if (st == 3'd5) begin
      v.instr_done = 1;
      if (op == 6'h23) begin v.reg_write = 1; v.mem_to_reg = 1; end
    end else if (st == 3'd7) begin
      v.illegal = 1;
    end
    return v;
  endfunction

  function automatic logic [2:0] next_st(input logic [2:0] s, input logic rst,
                                         input logic en, input logic [5:0] op);
    if (rst) return 3'd0;
    case (s)
      3'd0, 3'd5: return en ? 3'd1 : 3'd0;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      3'd2:       return known(op) ? 3'd3 : 3'd7;
`endif
      3'd7:       return 3'd7;
      default:    return s + 3'd1;
    endcase
  endfunction

  task automatic cyc(input logic [31:0] ir, input logic z, input logic en,
                     input logic rst, input string nm);
    item_t it;
    opcode = ir[31:26];
    funct  = ir[5:0];
    zero   = z;
    enable = en;
    reset  = rst;
    it.exp  = model(es, ir[31:26], ir[5:0], z, it.mask);
    it.name = $sformatf("%s_s%0d", nm, es);
    sb.push_back(it);
    @(posedge clk);
    #1;
    es = next_st(es, rst, en, ir[31:26]);
  endtask

  // n_en: number of leading cycles of the instruction with enable high
  task automatic instr(input logic [31:0] ir, input logic z, input int n_en, input string nm);
    for (int k = 0; k < 5; k++) cyc(ir, z, (k < n_en), 1'b0, nm);
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        n_checks++;
        if (((act ^ it.exp) & it.mask) != '0)
          $display("FAIL %s: got %h expected %h (mask %h)", it.name, act, it.exp, it.mask);
        else
          n_pass++;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: stimulus did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1; enable = 1; zero = 0; opcode = '0; funct = '0;
    @(posedge clk);
    #1;
    es = 3'd0;
    for (int i = 0; i < 3; i++) cyc(32'h0232_8020, 1'b0, 1'b1, 1'b1, "reset");
    cyc(32'h0232_8020, 1'b0, 1'b1, 1'b0, "idle_go");
    instr(32'h0232_8020, 1'b0, 5, "add");
    instr(32'h2231_0005, 1'b0, 5, "addi");
    instr(32'h1211_0002, 1'b1, 5, "beq_taken");
    instr(32'h1211_0002, 1'b0, 5, "beq_not");
    instr(32'h1611_0002, 1'b0, 5, "bne_taken");
    instr(32'h1611_0002, 1'b1, 5, "bne_not");
    instr(32'h0810_0002, 1'b1, 5, "j");
    instr(32'h8E08_0004, 1'b0, 5, "lw");
    instr(32'hAE08_0004, 1'b0, 5, "sw");
    instr(32'h0232_8022, 1'b0, 5, "sub");
    instr(32'h0232_8027, 1'b0, 5, "nor");
    instr(32'h0232_802A, 1'b0, 5, "slt");
    instr(32'h3210_000F, 1'b0, 5, "andi");
    instr(32'h3610_000F, 1'b0, 5, "ori");
    instr(32'h2A10_000F, 1'b0, 5, "slti");
    instr(32'h0232_803F, 1'b0, 5, "bad_funct");
    // enable falls while in EXECUTE: the instruction still completes
    instr(32'h2231_0005, 1'b0, 2, "en_drop");
    cyc(32'h2231_0005, 1'b0, 1'b0, 1'b0, "idle_hold");
    cyc(32'h2231_0005, 1'b0, 1'b1, 1'b0, "idle_go2");
    instr(32'hFC00_0000, 1'b0, 5, "bad_op");
    cyc(32'hFC00_0000, 1'b0, 1'b1, 1'b0, "after_bad");
    cyc(32'hFC00_0000, 1'b0, 1'b1, 1'b1, "reset_out");
    cyc(32'h0232_8020, 1'b0, 1'b0, 1'b0, "final_idle");
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
